// File: rtl/acc_tile_sequencer.sv
// Accumulator control for one output tile: compensation load, K-tile accumulation, row readout.
// Optional protocol checking is built only when ACC_SEQ_ERR_CHECK_EN is defined.
module acc_tile_sequencer #(
  parameter int ROWS       = 8,
  parameter int ADDR_W     = 3,
  parameter int TILE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  output logic                  busy,
  output logic                  done,
  input  logic                  comp_valid,
  input  logic                  psum_valid,
  output logic                  CACC_Wr_en,
  output logic [ADDR_W-1:0]     CAcc_Wr_Addr,
  output logic                  ACC_Wr_en,
  output logic [ADDR_W-1:0]     Acc_Wr_Addr,
  output logic                  Acc_Rd_en,
  output logic [ADDR_W-1:0]     Acc_Rd_Addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  seq_err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {IDLE, INIT, ACCUM, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0]     LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0]     ROW_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]       RD_ROWS  = (ADDR_W + 1)'(ROWS);
  localparam logic [ADDR_W:0]       RD_ONE   = (ADDR_W + 1)'(1);
  localparam logic [TILE_CNT_W-1:0] TILE_ONE = TILE_CNT_W'(1);

  state_t                state;
  logic [ADDR_W-1:0]     row;
  logic [ADDR_W-1:0]     acc_cnt;
  logic [ADDR_W:0]       rd_cnt;   // one extra bit so "all rows issued" is representable
  logic [TILE_CNT_W-1:0] tile;
  logic [TILE_CNT_W-1:0] tiles;
  logic                  accept;

  // Valid/ready: a row moves downstream in any cycle where out_valid && out_ready;
  // out_valid and the accumulator output register hold while out_ready is low.
  assign accept       = out_valid && out_ready;
  assign CACC_Wr_en   = (state == INIT)  && comp_valid;
  assign ACC_Wr_en    = (state == ACCUM) && psum_valid;
  assign Acc_Rd_en    = (state == READ) && (!out_valid || out_ready) && (rd_cnt < RD_ROWS);
  assign CAcc_Wr_Addr = row;
  assign Acc_Wr_Addr  = row;
  assign Acc_Rd_Addr  = rd_cnt[ADDR_W-1:0];
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      acc_cnt   <= '0;
      rd_cnt    <= '0;
      tile      <= '0;
      tiles     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tiles   <= num_tiles;
          row     <= '0;
          tile    <= '0;
          rd_cnt  <= '0;
          acc_cnt <= '0;
          busy    <= 1'b1;
          state   <= INIT;
        end
        INIT: if (comp_valid) begin
          if (row == LAST_ROW) begin
            row   <= '0;
            state <= (tiles == '0) ? READ : ACCUM;
          end else begin
            row <= row + ROW_ONE;
          end
        end
        ACCUM: if (psum_valid) begin
          if (row == LAST_ROW) begin
            row  <= '0;
            tile <= tile + TILE_ONE;
            if (tile + TILE_ONE == tiles) state <= READ;
          end else begin
            row <= row + ROW_ONE;
          end
        end
        READ: begin
          if (Acc_Rd_en) begin
            rd_cnt    <= rd_cnt + RD_ONE;
            out_valid <= 1'b1;
          end else if (accept) begin
            out_valid <= 1'b0;
          end
          if (accept) begin
            acc_cnt <= acc_cnt + ROW_ONE;
            if (acc_cnt == LAST_ROW) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_SEQ_ERR_CHECK_EN
  // Sticky until the next accepted start; the start itself wins over a same-cycle violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
    end else if (state == IDLE && start) begin
      seq_err <= 1'b0;
    end else if ((comp_valid && state != INIT) || (psum_valid && state != ACCUM) ||
                 (comp_valid && psum_valid)) begin
      seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_tile_sequencer.sv
// Bench for acc_tile_sequencer: random beat data through a behavioural accumulator, expected
// rows computed from beat order (beat b lands in row b mod ROWS), plus protocol/timing checks.
module tb_acc_tile_sequencer;
  localparam int ROWS = 8, ADDR_W = 3, TW = 8, DW = 16;
`ifdef ACC_SEQ_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 0, rst_n = 0, start = 0, comp_valid = 0, psum_valid = 0, out_ready = 0;
  logic [TW-1:0] num_tiles = '0;
  logic busy, done, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en, out_valid, seq_err;
  logic [ADDR_W-1:0] CAcc_Wr_Addr, Acc_Wr_Addr, Acc_Rd_Addr;
  logic [2:0] dbg_state;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] mem [ROWS];
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] exp_q[$];

  acc_tile_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W), .TILE_CNT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .busy(busy), .done(done),
    .comp_valid(comp_valid), .psum_valid(psum_valid),
    .CACC_Wr_en(CACC_Wr_en), .CAcc_Wr_Addr(CAcc_Wr_Addr),
    .ACC_Wr_en(ACC_Wr_en), .Acc_Wr_Addr(Acc_Wr_Addr),
    .Acc_Rd_en(Acc_Rd_en), .Acc_Rd_Addr(Acc_Rd_Addr),
    .out_valid(out_valid), .out_ready(out_ready), .seq_err(seq_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    comp_valid = 1; psum_valid = 1;
    #1;
    n_tests++;
    if ({busy, done, out_valid, seq_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_status: got %b expected 0000", {busy, done, out_valid, seq_err});
    end
    n_tests++;
    if ({CACC_Wr_en, ACC_Wr_en, Acc_Rd_en} !== 3'b0) begin
      n_fail++; $display("FAIL reset_enables: got %b expected 000", {CACC_Wr_en, ACC_Wr_en, Acc_Rd_en});
    end
    n_tests++;
    if ({CAcc_Wr_Addr, Acc_Wr_Addr, Acc_Rd_Addr} !== '0) begin
      n_fail++; $display("FAIL reset_addrs: got %h expected 0", {CAcc_Wr_Addr, Acc_Wr_Addr, Acc_Rd_Addr});
    end
    comp_valid = 0; psum_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // One full tile; psum_gap < 0 means psum_valid on alternate cycles.
  // ready_mode: 0 always ready, 1 random ready, 2 ready low for 5 cycles after the 3rd row.
  task automatic run_tile(input int n, input int comp_gap, input int psum_gap, input int ready_mode);
    logic [DW-1:0] cd [ROWS];
    logic [DW-1:0] exp_row [ROWS];
    logic [DW-1:0] pd_q[$];
    logic [DW-1:0] v, want;
    int comp_sent = 0, psum_sent = 0, cacc_seen = 0, acc_seen = 0, rd_seen = 0, accepts = 0;
    int last_wr = -1, first_rd = -1, last_rd = -1, last_acc = -1, done_cyc = -1, stall_left = 0;
    bit stalled = 0, consec = 1, prev_hold = 0, alt = 0, finished = 0;
    for (int r = 0; r < ROWS; r++) begin
      cd[r] = DW'($urandom); exp_row[r] = cd[r];
    end
    for (int b = 0; b < ROWS * n; b++) begin
      v = DW'($urandom); pd_q.push_back(v); exp_row[b % ROWS] += v;
    end
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(exp_row[r]);

    @(negedge clk);
    start = 1; num_tiles = TW'(n); comp_valid = 0; psum_valid = 0; out_ready = 1;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 400 && !finished; t++) begin
      if (t > 0) @(negedge clk);
      if (psum_gap < 0) begin
        alt = !alt;
        psum_valid = (comp_sent == ROWS) && (psum_sent < ROWS * n) && alt;
      end else begin
        psum_valid = (comp_sent == ROWS) && (psum_sent < ROWS * n) && ($urandom_range(99, 0) >= psum_gap);
      end
      comp_valid = (comp_sent < ROWS) && ($urandom_range(99, 0) >= comp_gap);
      if (comp_valid) comp_sent++;
      if (psum_valid) psum_sent++;
      case (ready_mode)
        0: out_ready = 1;
        1: out_ready = 1'($urandom_range(1, 0));
        default: begin
          if (accepts == 3 && !stalled) begin stalled = 1; stall_left = 5; end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      #1;
      if (t == 0) begin
        n_tests++;
        if ({busy, seq_err} !== 2'b10) begin
          n_fail++; $display("FAIL start_status: busy,seq_err got %b expected 10", {busy, seq_err});
        end
      end
      if (CACC_Wr_en || ACC_Wr_en || comp_valid || psum_valid) begin
        n_tests++;
        if ({CACC_Wr_en, ACC_Wr_en} !== {comp_valid, psum_valid}) begin
          n_fail++; $display("FAIL write_enables t=%0d: got %b expected %b", t, {CACC_Wr_en, ACC_Wr_en}, {comp_valid, psum_valid});
        end
      end
      if (CACC_Wr_en) begin
        n_tests++;
        if (CAcc_Wr_Addr !== ADDR_W'(cacc_seen % ROWS)) begin
          n_fail++; $display("FAIL cacc_addr beat %0d: got %0d expected %0d", cacc_seen, CAcc_Wr_Addr, cacc_seen % ROWS);
        end
        if (cacc_seen < ROWS) mem[CAcc_Wr_Addr] = cd[cacc_seen];
        cacc_seen++; last_wr = t;
      end
      if (ACC_Wr_en) begin
        n_tests++;
        if (Acc_Wr_Addr !== ADDR_W'(acc_seen % ROWS)) begin
          n_fail++; $display("FAIL acc_addr beat %0d: got %0d expected %0d", acc_seen, Acc_Wr_Addr, acc_seen % ROWS);
        end
        if (acc_seen < pd_q.size()) mem[Acc_Wr_Addr] = mem[Acc_Wr_Addr] + pd_q[acc_seen];
        acc_seen++; last_wr = t;
      end
      if (prev_hold) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL hold_valid t=%0d: got %b expected 1", t, out_valid);
        end
      end
      if (out_valid && !out_ready) begin
        n_tests++;
        if (Acc_Rd_en !== 1'b0) begin
          n_fail++; $display("FAIL stall_read t=%0d: got %b expected 0", t, Acc_Rd_en);
        end
      end
      prev_hold = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        n_tests++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : ~rdata;
        if (rdata !== want) begin
          n_fail++; $display("FAIL row_data row %0d: got %h expected %h", accepts, rdata, want);
        end
        accepts++; last_acc = t;
      end
      if (Acc_Rd_en) begin
        n_tests++;
        if (Acc_Rd_Addr !== ADDR_W'(rd_seen % ROWS) || last_wr >= t) begin
          n_fail++; $display("FAIL read_addr t=%0d: got %0d expected %0d (last write t=%0d)", t, Acc_Rd_Addr, rd_seen % ROWS, last_wr);
        end
        rdata = mem[Acc_Rd_Addr];
        if (first_rd < 0) first_rd = t;
        else if (t != last_rd + 1) consec = 0;
        last_rd = t; rd_seen++;
      end
      if (done && done_cyc < 0) done_cyc = t;
      if (done_cyc >= 0 && t == done_cyc + 1) begin
        n_tests++;
        if ({busy, done} !== 2'b00) begin
          n_fail++; $display("FAIL after_done: busy,done got %b expected 00", {busy, done});
        end
        finished = 1;
      end
    end
    comp_valid = 0; psum_valid = 0; out_ready = 1;
    n_tests++;
    if (!finished) begin
      n_fail++; $display("FAIL timeout n=%0d: done never seen (accepts %0d expected %0d)", n, accepts, ROWS);
    end
    n_tests++;
    if (cacc_seen != ROWS || acc_seen != ROWS * n || rd_seen != ROWS || accepts != ROWS) begin
      n_fail++; $display("FAIL beat_counts: got cacc %0d acc %0d rd %0d acc'd %0d expected %0d %0d %0d %0d",
                         cacc_seen, acc_seen, rd_seen, accepts, ROWS, ROWS * n, ROWS, ROWS);
    end
    n_tests++;
    if (done_cyc != last_acc + 1) begin
      n_fail++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_acc + 1);
    end
    n_tests++;
    if (seq_err !== 1'b0) begin
      n_fail++; $display("FAIL clean_seq_err: got %b expected 0", seq_err);
    end
    if (ready_mode == 0 && comp_gap == 0 && psum_gap == 0) begin
      n_tests++;
      if (!consec || first_rd != last_wr + 1) begin
        n_fail++; $display("FAIL throughput: consecutive %0d first read %0d expected %0d", consec, first_rd, last_wr + 1);
      end
    end
  endtask

  task automatic test_basic();          run_tile(2, 0, 0, 0);  endtask
  task automatic test_zero_tiles();     run_tile(0, 0, 0, 0);  endtask
  task automatic test_gapped();         run_tile(1, 0, -1, 0); run_tile(2, 40, -1, 0); endtask
  task automatic test_backpressure();   run_tile(2, 0, 0, 2);  endtask

  task automatic test_reset_mid_accum();
    @(negedge clk);
    start = 1; num_tiles = 2;
    @(negedge clk);
    start = 0; comp_valid = 1;
    repeat (ROWS) @(negedge clk);
    comp_valid = 0; psum_valid = 1;
    repeat (5) @(negedge clk);
    #1;
    n_tests++;
    if ({busy, ACC_Wr_en, Acc_Wr_Addr} !== {2'b11, 3'd5}) begin
      n_fail++; $display("FAIL mid_accum: busy,wr_en,addr got %b expected 11101", {busy, ACC_Wr_en, Acc_Wr_Addr});
    end
    rst_n = 0;
    #1;
    n_tests++;
    if ({busy, done, out_valid, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en, Acc_Wr_Addr, Acc_Rd_Addr} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %b expected all 0",
                         {busy, done, out_valid, CACC_Wr_en, ACC_Wr_en, Acc_Rd_en, Acc_Wr_Addr, Acc_Rd_Addr});
    end
    psum_valid = 0;
    @(negedge clk);
    rst_n = 1;
    run_tile(2, 0, 0, 0);
  endtask

  task automatic test_seq_err();
    bit got_done = 0;
    @(negedge clk);
    psum_valid = 1;
    #1;
    n_tests++;
    if ({CACC_Wr_en, ACC_Wr_en} !== 2'b00) begin
      n_fail++; $display("FAIL idle_stray_write: got %b expected 00", {CACC_Wr_en, ACC_Wr_en});
    end
    @(negedge clk);
    psum_valid = 0;
    #1;
    n_tests++;
    if (seq_err !== ERR_EN) begin
      n_fail++; $display("FAIL idle_seq_err: got %b expected %b", seq_err, ERR_EN);
    end
    @(negedge clk);
    start = 1; num_tiles = 0;
    @(negedge clk);
    start = 0; psum_valid = 1;
    #1;
    n_tests++;
    if ({seq_err, CACC_Wr_en, ACC_Wr_en} !== 3'b000) begin
      n_fail++; $display("FAIL init_stray_psum: seq_err,cacc,acc got %b expected 000", {seq_err, CACC_Wr_en, ACC_Wr_en});
    end
    @(negedge clk);
    psum_valid = 0; comp_valid = 1;
    #1;
    n_tests++;
    if (seq_err !== ERR_EN) begin
      n_fail++; $display("FAIL init_seq_err: got %b expected %b", seq_err, ERR_EN);
    end
    repeat (ROWS - 1) @(negedge clk);
    @(negedge clk);
    comp_valid = 0; out_ready = 1;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      #1;
      if (done) got_done = 1;
    end
    n_tests++;
    if (!got_done || seq_err !== ERR_EN) begin
      n_fail++; $display("FAIL seq_err_sticky: done %0d seq_err %b expected 1 %b", got_done, seq_err, ERR_EN);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_tile($urandom_range(3, 1), $urandom_range(50, 0), $urandom_range(50, 0), 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_tiles();
    test_gapped();
    test_backpressure();
    test_reset_mid_accum();
    test_seq_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
